// File: rtl/aes_pkg.sv
// Shared AES definitions used by the encryptor and the decryptor tops.
package aes_pkg;

   localparam int NR       = 10;
   localparam int SELKEY_W = 4;

   localparam logic [7:0] GF_POLY = 8'h1B;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      FINAL = 2'd2,
      DONE  = 2'd3
   } aesStateT;

   // Multiply by x in GF(2^8), reducing by the AES polynomial 0x11B
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box for a single byte.
module aes_sbox (
   input  logic [7:0] value,
   output logic [7:0] result
);

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign result = SBOX[value];

endmodule

// File: rtl/aes_encryptor.sv
// Iterative AES-128 encryptor: one round per clock, round keys supplied
// externally through the SelKey/Key lookup.
module aes_encryptor
   import aes_pkg::*;
#(
   parameter int NR = 10
) (
   input  logic                Clk,
   input  logic                Rst,
   input  logic                En,
   input  logic [127:0]        Key,
   input  logic [127:0]        PT,
   output logic [SELKEY_W-1:0] SelKey,
   output logic                Ry,
   output logic [127:0]        CT
);

   aesStateT state, nextState;

   logic [SELKEY_W-1:0] counter;
   logic [127:0]        data;
   logic [127:0]        ctReg;
   logic                ryReg;

   logic                loadStart;
   logic                roundStep;
   logic                finalStep;

   logic [7:0]          sb [16];
   logic [7:0]          sr [16];
   logic [7:0]          mc [16];
   logic [127:0]        roundOut;
   logic [127:0]        finalOut;

   assign SelKey = counter;
   assign Ry     = ryReg;
   assign CT     = ctReg;

   for (genvar i = 0; i < 16; i++) begin : gSbox
      aes_sbox uSbox (
         .value  (data[127-8*i -: 8]),
         .result (sb[i])
      );
   end

   // ShiftRows, MixColumns and AddRoundKey for both the full and final round
   always_comb begin
      sr       = '{default: '0};
      mc       = '{default: '0};
      roundOut = '0;
      finalOut = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
         end
      end
      for (int c = 0; c < 4; c++) begin
         mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
         mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
         mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
         mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
      end
      for (int i = 0; i < 16; i++) begin
         roundOut[127-8*i -: 8] = mc[i] ^ Key[127-8*i -: 8];
         finalOut[127-8*i -: 8] = sr[i] ^ Key[127-8*i -: 8];
      end
   end

   // State register; reset aborts any operation in flight
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state decode and the datapath step to perform on this edge
   always_comb begin
      nextState = state;
      loadStart = 1'b0;
      roundStep = 1'b0;
      finalStep = 1'b0;
      unique case (state)
         IDLE: begin
            if (En) begin
               loadStart = 1'b1;
               nextState = ROUND;
            end
         end
         ROUND: begin
            roundStep = 1'b1;
            if (counter == SELKEY_W'(NR - 1)) begin
               nextState = FINAL;
            end
         end
         FINAL: begin
            finalStep = 1'b1;
            nextState = DONE;
         end
         DONE: begin
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Round counter, state data and registered outputs; CT only moves at the final round
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         counter <= '0;
         data    <= '0;
         ctReg   <= '0;
         ryReg   <= 1'b0;
      end else begin
         ryReg <= finalStep;
         if (loadStart) begin
            data    <= PT ^ Key;
            counter <= SELKEY_W'(1);
         end else if (roundStep) begin
            data    <= roundOut;
            counter <= counter + 1'b1;
         end else if (finalStep) begin
            ctReg   <= finalOut;
            counter <= '0;
         end
      end
   end

endmodule
